// File: rtl/program_counter_stack_if.sv
// Control and status bundle between the CPU microcode sequencer and the program counter.
// The shared tri-state bus stays a plain inout port on the counter itself.
interface program_counter_stack_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned SP_W   = 3
);
    logic              inc;
    logic              jump;
    logic              jc;
    logic              jz;
    logic              call;
    logic              ret;
    logic              flag_c;
    logic              flag_z;
    logic              out;
    logic              fault_clr;
    logic [ADDR_W-1:0] pc;
    logic [SP_W-1:0]   sp;
    logic              stack_empty;
    logic              stack_full;
    logic              fault;

    modport master (
        output inc, jump, jc, jz, call, ret, flag_c, flag_z, out, fault_clr,
        input  pc, sp, stack_empty, stack_full, fault
    );

    modport slave (
        input  inc, jump, jc, jz, call, ret, flag_c, flag_z, out, fault_clr,
        output pc, sp, stack_empty, stack_full, fault
    );
endinterface

// File: rtl/program_counter_stack.sv
// Program counter with return-address stack, conditional jumps and sticky fault flag.
// Loads come from the shared bus; the count is driven back onto it when out is set.
module program_counter_stack #(
    parameter int unsigned              BUS_W       = 8,
    parameter int unsigned              ADDR_W      = 4,
    parameter int unsigned              STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]        RESET_ADDR  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    program_counter_stack_if.slave ctl,
    inout  wire  [BUS_W-1:0]     bus
);
    localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0] count_q, count_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic [ADDR_W-1:0] count_inc;
    logic [ADDR_W-1:0] bus_val;
    logic [ADDR_W-1:0] stack_top;
    logic              full;
    logic              empty;
    logic              multi_cmd;
    logic              out_conflict;
    logic              push;
    logic              new_fault;

    assign count_inc = count_q + ADDR_W'(1);
    assign bus_val   = bus[ADDR_W-1:0];
    assign full      = (sp_q == SP_W'(STACK_DEPTH));
    assign empty     = (sp_q == '0);

    // Not-taken conditionals still count as commands for conflict detection.
    assign multi_cmd = ($countones({ctl.inc, ctl.jump, ctl.jc, ctl.jz, ctl.call, ctl.ret}) > 1);
    assign out_conflict = ctl.out & (ctl.jump | ctl.jc | ctl.jz | ctl.call);

    always_comb begin
        stack_top = '0;
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) stack_top = stack_q[i];
        end
    end

    always_comb begin
        count_d   = count_q;
        sp_d      = sp_q;
        push      = 1'b0;
        new_fault = 1'b0;
        if (multi_cmd || out_conflict) begin
            new_fault = 1'b1;
        end else if (ctl.inc) begin
            count_d = count_inc;
        end else if (ctl.jump) begin
            count_d = bus_val;
        end else if (ctl.jc) begin
            if (ctl.flag_c) count_d = bus_val;
        end else if (ctl.jz) begin
            if (ctl.flag_z) count_d = bus_val;
        end else if (ctl.call) begin
            if (full) begin
                new_fault = 1'b1;
            end else begin
                push    = 1'b1;
                sp_d    = sp_q + SP_W'(1);
                count_d = bus_val;
            end
        end else if (ctl.ret) begin
            if (empty) begin
                new_fault = 1'b1;
            end else begin
                sp_d    = sp_q - SP_W'(1);
                count_d = stack_top;
            end
        end
        // A fault raised in the same cycle as fault_clr wins.
        fault_d = new_fault | (fault_q & ~ctl.fault_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RESET_ADDR;
            sp_q    <= '0;
            fault_q <= 1'b0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            count_q <= count_d;
            sp_q    <= sp_d;
            fault_q <= fault_d;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                if (push && (sp_q == SP_W'(i))) stack_q[i] <= count_inc;
            end
        end
    end

    assign bus = (ctl.out && rst_n) ? BUS_W'(count_q) : 'z;

    assign ctl.pc          = count_q;
    assign ctl.sp          = sp_q;
    assign ctl.stack_empty = empty;
    assign ctl.stack_full  = full;
    assign ctl.fault       = fault_q;
endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench for program_counter_stack with a queue-based reference model and
// a per-cycle compare process, plus literal checks along the directed sequence.
module tb_program_counter_stack;
    localparam int unsigned BUS_W  = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SP_W   = 3;
    localparam int          MODV   = 1 << ADDR_W;

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_INC  = 6'b100000;
    localparam logic [5:0] C_JUMP = 6'b010000;
    localparam logic [5:0] C_JC   = 6'b001000;
    localparam logic [5:0] C_JZ   = 6'b000100;
    localparam logic [5:0] C_CALL = 6'b000010;
    localparam logic [5:0] C_RET  = 6'b000001;

    logic             clk;
    logic             rst_n;
    logic             drv_en;
    logic [BUS_W-1:0] drv_val;
    wire  [BUS_W-1:0] bus;

    assign bus = drv_en ? drv_val : 'z;

    program_counter_stack_if #(.ADDR_W(ADDR_W), .SP_W(SP_W)) ctl ();

    program_counter_stack #(
        .BUS_W      (BUS_W),
        .ADDR_W     (ADDR_W),
        .STACK_DEPTH(DEPTH),
        .RESET_ADDR (4'h3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ctl  (ctl),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit checking = 0;

    // Reference model: plain integer count and a queue as the return stack.
    int m_pc;
    int m_stack[$];
    bit m_fault;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endtask

    task automatic model_reset();
        m_pc = 3;
        m_stack.delete();
        m_fault = 0;
    endtask

    task automatic model_step();
        int n;
        int bv;
        bit nf;
        n  = int'(ctl.inc) + int'(ctl.jump) + int'(ctl.jc) + int'(ctl.jz)
           + int'(ctl.call) + int'(ctl.ret);
        bv = int'(bus) % MODV;
        nf = 0;
        if (n > 1 || (ctl.out && (ctl.jump || ctl.jc || ctl.jz || ctl.call))) nf = 1;
        else if (ctl.inc) m_pc = (m_pc + 1) % MODV;
        else if (ctl.jump) m_pc = bv;
        else if (ctl.jc) begin
            if (ctl.flag_c) m_pc = bv;
        end else if (ctl.jz) begin
            if (ctl.flag_z) m_pc = bv;
        end else if (ctl.call) begin
            if (m_stack.size() == DEPTH) nf = 1;
            else begin
                m_stack.push_back((m_pc + 1) % MODV);
                m_pc = bv;
            end
        end else if (ctl.ret) begin
            if (m_stack.size() == 0) nf = 1;
            else m_pc = m_stack.pop_back();
        end
        m_fault = nf || (m_fault && !ctl.fault_clr);
    endtask

    // Drive one cycle of inputs, let the edge happen, then advance the model.
    task automatic apply(input logic [5:0] cmd, input logic fc, input logic fz,
                         input logic o, input logic fclr, input logic [7:0] b);
        {ctl.inc, ctl.jump, ctl.jc, ctl.jz, ctl.call, ctl.ret} = cmd;
        ctl.flag_c    = fc;
        ctl.flag_z    = fz;
        ctl.out       = o;
        ctl.fault_clr = fclr;
        drv_en        = !o;
        drv_val       = b;
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("model_pc", int'(ctl.pc), m_pc);
            chk("model_sp", int'(ctl.sp), m_stack.size());
            chk("model_empty", int'(ctl.stack_empty), int'(m_stack.size() == 0));
            chk("model_full", int'(ctl.stack_full), int'(m_stack.size() == DEPTH));
            chk("model_fault", int'(ctl.fault), int'(m_fault));
            if (ctl.out && rst_n) chk("model_bus_driven", int'(bus), m_pc);
            else chk("model_bus_released", int'(bus), int'(drv_val));
        end
    end

    initial begin
        {ctl.inc, ctl.jump, ctl.jc, ctl.jz, ctl.call, ctl.ret} = C_NONE;
        ctl.flag_c = 0; ctl.flag_z = 0; ctl.fault_clr = 0;
        // Out asserted in reset with the bench driving: DUT must stay off the bus.
        ctl.out = 1; drv_en = 1; drv_val = 8'h50;
        rst_n = 0;
        model_reset();
        #12;
        chk("reset_pc", int'(ctl.pc), 3);
        chk("reset_sp", int'(ctl.sp), 0);
        chk("reset_empty", int'(ctl.stack_empty), 1);
        chk("reset_full", int'(ctl.stack_full), 0);
        chk("reset_fault", int'(ctl.fault), 0);
        chk("reset_bus_z", int'(bus), 8'h50);
        ctl.out = 0; drv_val = 8'h00;
        #11 rst_n = 1;
        checking = 1;

        for (int i = 0; i < 13; i++) apply(C_INC, 0, 0, 0, 0, 8'h00);
        chk("inc_wrap_pc", int'(ctl.pc), 0);
        apply(C_NONE, 0, 0, 1, 0, 8'h00);
        chk("out_bus_zero", int'(bus), 8'h00);

        apply(C_JC, 0, 0, 0, 0, 8'hA7);
        chk("jc_not_taken", int'(ctl.pc), 0);
        apply(C_JC, 1, 0, 0, 0, 8'hA7);
        chk("jc_taken", int'(ctl.pc), 7);
        apply(C_JZ, 0, 1, 0, 0, 8'h02);
        chk("jz_taken", int'(ctl.pc), 2);

        apply(C_JUMP, 0, 0, 0, 0, 8'h05);
        apply(C_CALL, 0, 0, 0, 0, 8'h09);
        chk("call1_pc", int'(ctl.pc), 9);
        chk("call1_sp", int'(ctl.sp), 1);
        apply(C_CALL, 0, 0, 0, 0, 8'h0C);
        chk("call2_pc", int'(ctl.pc), 12);
        chk("call2_sp", int'(ctl.sp), 2);
        apply(C_RET, 0, 0, 0, 0, 8'h00);
        chk("ret1_pc", int'(ctl.pc), 10);
        apply(C_RET, 0, 0, 0, 0, 8'h00);
        chk("ret2_pc", int'(ctl.pc), 6);
        chk("ret2_sp", int'(ctl.sp), 0);

        for (int i = 1; i <= 4; i++) apply(C_CALL, 0, 0, 0, 0, 8'(i));
        chk("fill_full", int'(ctl.stack_full), 1);
        apply(C_CALL, 0, 0, 0, 0, 8'h08);
        chk("overflow_pc", int'(ctl.pc), 4);
        chk("overflow_sp", int'(ctl.sp), 4);
        chk("overflow_fault", int'(ctl.fault), 1);
        apply(C_NONE, 0, 0, 0, 1, 8'h00);
        chk("fault_clr", int'(ctl.fault), 0);
        for (int i = 0; i < 4; i++) apply(C_RET, 0, 0, 0, 0, 8'h00);
        chk("unwind_pc", int'(ctl.pc), 7);
        apply(C_RET, 0, 0, 0, 0, 8'h00);
        chk("underflow_pc", int'(ctl.pc), 7);
        chk("underflow_fault", int'(ctl.fault), 1);
        apply(C_NONE, 0, 0, 0, 1, 8'h00);

        apply(C_INC | C_JUMP, 0, 0, 0, 0, 8'h03);
        chk("multi_pc", int'(ctl.pc), 7);
        chk("multi_fault", int'(ctl.fault), 1);
        apply(C_NONE, 0, 0, 0, 1, 8'h00);
        apply(C_CALL, 0, 0, 1, 0, 8'h00);
        chk("out_call_bus", int'(bus), 7);
        chk("out_call_sp", int'(ctl.sp), 0);
        chk("out_call_fault", int'(ctl.fault), 1);
        apply(C_INC | C_RET, 0, 0, 0, 1, 8'h00);
        chk("clr_vs_new_fault", int'(ctl.fault), 1);
        apply(C_NONE, 0, 0, 0, 1, 8'h00);
        apply(C_JC, 0, 0, 1, 0, 8'h00);
        chk("out_jc_nt_fault", int'(ctl.fault), 1);
        apply(C_NONE, 0, 0, 0, 1, 8'h00);

        apply(C_CALL, 0, 0, 0, 0, 8'h0A);
        apply(C_CALL, 0, 0, 0, 0, 8'h0B);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        chk("async_rst_pc", int'(ctl.pc), 3);
        chk("async_rst_sp", int'(ctl.sp), 0);
        chk("async_rst_fault", int'(ctl.fault), 0);
        apply(C_NONE, 0, 0, 0, 0, 8'h00);
        rst_n = 1;
        apply(C_RET, 0, 0, 0, 0, 8'h00);
        chk("post_rst_ret_fault", int'(ctl.fault), 1);
        chk("post_rst_ret_pc", int'(ctl.pc), 3);
        apply(C_NONE, 0, 0, 0, 0, 8'h00);

        @(posedge clk);
        checking = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
